// File: rtl/brick_grid_mem.sv
// Brick-field store: COLS x ROWS grid of health values with pixel-to-cell mapping,
// atomic HIT (read-decrement-write), whole-grid INIT sequencer and live-brick counter.
module brick_grid_mem #(
    parameter int COLS     = 16,
    parameter int ROWS     = 8,
    parameter int BRICK_W  = 20,
    parameter int BRICK_H  = 10,
    parameter int HEALTH_W = 2,
    parameter int XY_W     = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [XY_W-1:0]                   x_in,
    input  logic [XY_W-1:0]                   y_in,
    input  logic [HEALTH_W-1:0]               health_in,
    output logic                              rsp_valid,
    output logic [HEALTH_W-1:0]               health,
    output logic [XY_W-1:0]                   x,
    output logic [XY_W-1:0]                   y,
    output logic                              in_grid,
    output logic                              hit,
    output logic                              destroyed,
    output logic [$clog2(COLS*ROWS+1)-1:0]    bricks_left,
    output logic                              all_clear,
    output logic                              busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam int          ADDR_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int          CNT_W     = $clog2(CELLS + 1);
    localparam int unsigned U_COLS    = COLS;
    localparam int unsigned GRID_W_PX = COLS * BRICK_W;
    localparam int unsigned GRID_H_PX = ROWS * BRICK_H;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_HIT    = 2'b01,
        OP_INIT   = 2'b10,
        OP_SET    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RSP,
        S_FILL
    } state_t;

    state_t              r_state;
    state_t              w_next;
    op_t                 r_op;
    logic [HEALTH_W-1:0] r_mem [CELLS];
    logic [HEALTH_W-1:0] r_rdata;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cmd_in_grid;
    logic [XY_W-1:0]     r_x_org;
    logic [XY_W-1:0]     r_y_org;
    logic [HEALTH_W-1:0] r_hin;
    logic [CNT_W-1:0]    r_fill_cnt;
    logic [CNT_W-1:0]    r_bricks;
    logic                r_loaded;
    logic                r_rsp_valid;
    logic [HEALTH_W-1:0] r_health;
    logic [XY_W-1:0]     r_x;
    logic [XY_W-1:0]     r_y;
    logic                r_in_grid;
    logic                r_hit;
    logic                r_destroyed;

    logic                w_accept;
    logic [XY_W-1:0]     w_col;
    logic [XY_W-1:0]     w_row;
    logic [XY_W-1:0]     w_x_org;
    logic [XY_W-1:0]     w_y_org;
    logic                w_in_grid;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [HEALTH_W-1:0] w_wdata;
    logic [HEALTH_W-1:0] w_rsp_health;
    logic                w_rsp_hit;
    logic                w_rsp_destroyed;
    logic                w_cnt_inc;
    logic                w_cnt_dec;
    logic                w_fill_done;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_col     = x_in / XY_W'(BRICK_W);
    assign w_row     = y_in / XY_W'(BRICK_H);
    assign w_x_org   = w_col * XY_W'(BRICK_W);
    assign w_y_org   = w_row * XY_W'(BRICK_H);
    assign w_in_grid = (32'(x_in) < GRID_W_PX) && (32'(y_in) < GRID_H_PX);
    // Out-of-grid commands never touch storage, so park the address at 0 to keep reads in range.
    assign w_addr    = w_in_grid ? ADDR_W'(32'(w_row) * U_COLS + 32'(w_col)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_we            = 1'b0;
        w_waddr         = r_addr;
        w_wdata         = r_hin;
        w_rsp_health    = '0;
        w_rsp_hit       = 1'b0;
        w_rsp_destroyed = 1'b0;
        w_cnt_inc       = 1'b0;
        w_cnt_dec       = 1'b0;
        w_fill_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (op_t'(cmd_op) == OP_INIT) ? S_FILL : S_RD;
                end
            end
            S_RD: begin
                w_next = S_RSP;
            end
            S_RSP: begin
                w_next = S_IDLE;
                if (r_cmd_in_grid) begin
                    case (r_op)
                        OP_LOOKUP: begin
                            w_rsp_health = r_rdata;
                        end
                        OP_HIT: begin
                            if (r_rdata != '0) begin
                                w_we            = 1'b1;
                                w_wdata         = r_rdata - HEALTH_W'(1);
                                w_rsp_health    = r_rdata - HEALTH_W'(1);
                                w_rsp_hit       = 1'b1;
                                w_rsp_destroyed = (r_rdata == HEALTH_W'(1));
                                w_cnt_dec       = (r_rdata == HEALTH_W'(1));
                            end
                        end
                        OP_SET: begin
                            w_we         = 1'b1;
                            w_wdata      = r_hin;
                            w_rsp_health = r_hin;
                            w_cnt_inc    = (r_rdata == '0) && (r_hin != '0);
                            w_cnt_dec    = (r_rdata != '0) && (r_hin == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_FILL: begin
                // One extra cycle after the last write gives the INIT response its fixed latency.
                if (r_fill_cnt == CNT_W'(CELLS)) begin
                    w_fill_done = 1'b1;
                    w_next      = S_IDLE;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = ADDR_W'(r_fill_cnt);
                    w_wdata = r_hin;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (r_state == S_RD) begin
            r_rdata <= r_mem[r_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op          <= OP_LOOKUP;
            r_addr        <= '0;
            r_cmd_in_grid <= 1'b0;
            r_x_org       <= '0;
            r_y_org       <= '0;
            r_hin         <= '0;
            r_fill_cnt    <= '0;
            r_bricks      <= '0;
            r_loaded      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_health      <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_in_grid     <= 1'b0;
            r_hit         <= 1'b0;
            r_destroyed   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_op          <= op_t'(cmd_op);
                r_addr        <= w_addr;
                r_cmd_in_grid <= w_in_grid;
                r_x_org       <= w_x_org;
                r_y_org       <= w_y_org;
                r_hin         <= health_in;
                r_fill_cnt    <= '0;
            end
            if ((r_state == S_FILL) && !w_fill_done) begin
                r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            end
            if (r_state == S_RSP) begin
                r_rsp_valid <= 1'b1;
                r_health    <= w_rsp_health;
                r_x         <= r_x_org;
                r_y         <= r_y_org;
                r_in_grid   <= r_cmd_in_grid;
                r_hit       <= w_rsp_hit;
                r_destroyed <= w_rsp_destroyed;
            end
            if (w_cnt_inc) begin
                r_bricks <= r_bricks + CNT_W'(1);
            end else if (w_cnt_dec) begin
                r_bricks <= r_bricks - CNT_W'(1);
            end
            if (w_fill_done) begin
                r_rsp_valid <= 1'b1;
                r_health    <= r_hin;
                r_hit       <= 1'b0;
                r_destroyed <= 1'b0;
                r_bricks    <= (r_hin != '0) ? CNT_W'(CELLS) : '0;
                r_loaded    <= 1'b1;
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        w_cnt_dec |-> (r_bricks != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_cnt_inc |-> (r_bricks != CNT_W'(CELLS)));

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign health      = r_health;
    assign x           = r_x;
    assign y           = r_y;
    assign in_grid     = r_in_grid;
    assign hit         = r_hit;
    assign destroyed   = r_destroyed;
    assign bricks_left = r_bricks;
    assign all_clear   = r_loaded && (r_bricks == '0);

endmodule

// File: tb/tb_brick_grid_mem.sv
// Self-checking bench for brick_grid_mem: behavioural grid model plus directed and random commands.
module tb_brick_grid_mem;

    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int BW   = 20;
    localparam int BH   = 10;
    localparam int N    = COLS * ROWS;

    localparam int OP_LOOKUP = 0;
    localparam int OP_HIT    = 1;
    localparam int OP_INIT   = 2;
    localparam int OP_SET    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic [1:0] health_in = '0;
    logic       rsp_valid;
    logic [1:0] health;
    logic [9:0] x;
    logic [9:0] y;
    logic       in_grid;
    logic       hit;
    logic       destroyed;
    logic [7:0] bricks_left;
    logic       all_clear;
    logic       busy;

    logic       s_cmd_valid = 1'b0;
    logic       s_cmd_ready;
    logic [1:0] s_cmd_op = 2'd0;
    logic [9:0] s_x_in = '0;
    logic [9:0] s_y_in = '0;
    logic [1:0] s_health_in = '0;
    logic       s_rsp_valid;
    logic [1:0] s_health;
    logic [9:0] s_x;
    logic [9:0] s_y;
    logic       s_in_grid;
    logic       s_hit;
    logic       s_destroyed;
    logic [3:0] s_bricks_left;
    logic       s_all_clear;
    logic       s_busy;

    brick_grid_mem #(.COLS(COLS), .ROWS(ROWS), .BRICK_W(BW), .BRICK_H(BH), .HEALTH_W(2), .XY_W(10)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .x_in(x_in), .y_in(y_in), .health_in(health_in), .rsp_valid(rsp_valid), .health(health),
        .x(x), .y(y), .in_grid(in_grid), .hit(hit), .destroyed(destroyed),
        .bricks_left(bricks_left), .all_clear(all_clear), .busy(busy)
    );

    brick_grid_mem #(.COLS(4), .ROWS(2), .BRICK_W(BW), .BRICK_H(BH), .HEALTH_W(2), .XY_W(10)) dut_small (
        .clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
        .x_in(s_x_in), .y_in(s_y_in), .health_in(s_health_in), .rsp_valid(s_rsp_valid), .health(s_health),
        .x(s_x), .y(s_y), .in_grid(s_in_grid), .hit(s_hit), .destroyed(s_destroyed),
        .bricks_left(s_bricks_left), .all_clear(s_all_clear), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: grid contents plus committed count/loaded flag.
    int m_mem [N];
    int m_bricks = 0;
    int m_loaded = 0;

    bit pend = 0;
    int p_op, acc_cyc;
    int e_health, e_x, e_y, e_ing, e_hit, e_des, e_bricks, e_loaded, e_lat;

    task automatic predict(input int op, input int xi, input int yi, input int h);
        int col, row, addr, old;
        col      = xi / BW;
        row      = yi / BH;
        e_ing    = (xi < COLS * BW && yi < ROWS * BH) ? 1 : 0;
        e_x      = (col * BW) % 1024;
        e_y      = (row * BH) % 1024;
        e_health = 0;
        e_hit    = 0;
        e_des    = 0;
        e_lat    = 2;
        e_loaded = m_loaded;
        if (op == OP_INIT) begin
            for (int i = 0; i < N; i++) m_mem[i] = h;
            e_lat    = N + 1;
            e_loaded = 1;
            e_health = h;
        end else if (e_ing == 1) begin
            addr = row * COLS + col;
            old  = m_mem[addr];
            case (op)
                OP_LOOKUP: e_health = old;
                OP_HIT: if (old > 0) begin
                    m_mem[addr] = old - 1;
                    e_health    = old - 1;
                    e_hit       = 1;
                    e_des       = (old == 1) ? 1 : 0;
                end
                OP_SET: begin
                    m_mem[addr] = h;
                    e_health    = h;
                end
                default: ;
            endcase
        end
        e_bricks = 0;
        for (int i = 0; i < N; i++) if (m_mem[i] != 0) e_bricks++;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (pend && rsp_valid) begin
                check("latency", cyc - acc_cyc, e_lat);
                if (p_op != OP_INIT) begin
                    check("health", int'(health), e_health);
                    check("x", int'(x), e_x);
                    check("y", int'(y), e_y);
                    check("in_grid", int'(in_grid), e_ing);
                end
                check("hit", int'(hit), e_hit);
                check("destroyed", int'(destroyed), e_des);
                check("bricks_left", int'(bricks_left), e_bricks);
                check("all_clear", int'(all_clear), (e_loaded == 1 && e_bricks == 0) ? 1 : 0);
                m_bricks = e_bricks;
                m_loaded = e_loaded;
                pend     = 0;
            end else begin
                if (!pend) check("spurious_rsp", int'(rsp_valid), 0);
                check("bricks_held", int'(bricks_left), m_bricks);
                check("all_clear_held", int'(all_clear), (m_loaded == 1 && m_bricks == 0) ? 1 : 0);
            end
        end
    end

    task automatic start_cmd(input int op, input int xi, input int yi, input int h);
        int w;
        w = 0;
        @(negedge clk); #1;
        while (!cmd_ready && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        if (!cmd_ready) check("ready_timeout", int'(cmd_ready), 1);
        predict(op, xi, yi, h);
        p_op      = op;
        pend      = 1;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        x_in      = 10'(xi);
        y_in      = 10'(yi);
        health_in = 2'(h);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        x_in      = 10'($urandom);
        y_in      = 10'($urandom);
        health_in = 2'($urandom);
        cmd_op    = 2'($urandom);
    endtask

    task automatic finish_cmd();
        int t;
        t = 0;
        while (pend && t < N + 20) begin
            @(negedge clk); #1;
            t++;
        end
        if (pend) begin
            check("rsp_timeout", int'(pend), 0);
            pend = 0;
        end
    endtask

    task automatic cmd(input int op, input int xi, input int yi, input int h);
        start_cmd(op, xi, yi, h);
        finish_cmd();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s_acc, t;
        for (int i = 0; i < N; i++) m_mem[i] = 0;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_health", int'(health), 0);
        check("rst_x", int'(x), 0);
        check("rst_in_grid", int'(in_grid), 0);
        check("rst_bricks", int'(bricks_left), 0);
        check("rst_all_clear", int'(all_clear), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        #2 reset = 1'b0;

        // Small 4x2 grid: INIT latency is accept + 9.
        @(negedge clk); #1;
        s_cmd_valid = 1'b1; s_cmd_op = 2'd2; s_health_in = 2'd3;
        @(posedge clk); #1;
        s_acc = cyc; s_cmd_valid = 1'b0; s_health_in = 2'd0;
        check("small_busy", int'(s_busy), 1);
        t = 0;
        while (!s_rsp_valid && t < 30) begin @(negedge clk); t++; end
        check("small_init_lat", cyc - s_acc, 9);
        check("small_bricks", int'(s_bricks_left), 8);
        check("small_all_clear", int'(s_all_clear), 0);

        cmd(OP_INIT, 0, 0, 3);
        check("lit_init_bricks", int'(bricks_left), 128);
        cmd(OP_LOOKUP, 45, 12, 0);
        check("lit_lookup_x", int'(x), 40);
        check("lit_lookup_y", int'(y), 10);
        check("lit_lookup_ing", int'(in_grid), 1);
        check("lit_lookup_health", int'(health), 3);

        for (int k = 0; k < 3; k++) begin
            cmd(OP_HIT, 45, 12, 0);
            check("lit_hit_health", int'(health), 2 - k);
            check("lit_hit_destroyed", int'(destroyed), (k == 2) ? 1 : 0);
            check("lit_hit_bricks", int'(bricks_left), (k == 2) ? 127 : 128);
        end
        cmd(OP_HIT, 45, 12, 0);
        check("lit_hit4_hit", int'(hit), 0);
        check("lit_hit4_bricks", int'(bricks_left), 127);

        cmd(OP_HIT, 320, 5, 0);
        check("lit_oog_ing", int'(in_grid), 0);
        check("lit_oog_x", int'(x), 320);
        check("lit_oog_health", int'(health), 0);
        cmd(OP_LOOKUP, 0, 10, 0);
        check("lit_oog_cell16", int'(health), 3);

        // A command presented while busy must be dropped.
        start_cmd(OP_LOOKUP, 21, 0, 0);
        cmd_valid = 1'b1; cmd_op = 2'd3; x_in = '0; y_in = '0; health_in = '0;
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b0;
        finish_cmd();
        repeat (4) @(negedge clk);
        cmd(OP_LOOKUP, 0, 0, 0);
        check("lit_dropped_set", int'(health), 3);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cmd(OP_SET, c * BW + 1, r * BH + 3, 0);
        check("lit_clear_bricks", int'(bricks_left), 0);
        check("lit_clear_all", int'(all_clear), 1);
        cmd(OP_SET, 100, 50, 2);
        check("lit_set_bricks", int'(bricks_left), 1);
        check("lit_set_all", int'(all_clear), 0);

        cmd(OP_INIT, 0, 0, int'($urandom_range(1, 3)));
        for (int k = 0; k < 250; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 2) op = OP_SET;
            if ($urandom_range(0, 59) == 0) op = OP_INIT;
            cmd(op, int'($urandom_range(0, 359)), int'($urandom_range(0, 99)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a fill.
        start_cmd(OP_INIT, 0, 0, 2);
        repeat (20) @(posedge clk);
        #3;
        pend   = 0;
        reset  = 1'b1;
        #1;
        m_bricks = 0;
        m_loaded = 0;
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_health", int'(health), 0);
        check("midrst_hit", int'(hit), 0);
        check("midrst_bricks", int'(bricks_left), 0);
        check("midrst_all_clear", int'(all_clear), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(cmd_ready), 1);
        @(posedge clk); #3 reset = 1'b0;
        repeat (5) @(negedge clk);
        cmd(OP_INIT, 0, 0, 1);
        cmd(OP_HIT, 319, 79, 0);
        check("lit_final_bricks", int'(bricks_left), 127);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brick_grid_mem.md
Name: brick_grid_mem

Overview:
- Parametrised brick-field store for BrickBreaker: COLS x ROWS grid of bricks, each holding a HEALTH_W-bit health value.
- Maps pixel coordinates to a brick cell and returns the cell's pixel origin.
- Adds a command handshake, atomic hit (read-decrement-write), a whole-grid init sequencer, and a live-brick counter.
- Sits between the ball collision logic and the renderer; the renderer uses LOOKUP, the collision FSM uses HIT.

Parameters:
- COLS, 16, bricks per row.
- ROWS, 8, brick rows.
- BRICK_W, 20, brick width in pixels.
- BRICK_H, 10, brick height in pixels.
- HEALTH_W, 2, health bits per brick; 0 means no brick.
- XY_W, 10, pixel coordinate width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  2  00 LOOKUP, 01 HIT, 10 INIT, 11 SET.
- x_in  in  XY_W  pixel x (ignored for INIT).
- y_in  in  XY_W  pixel y (ignored for INIT).
- health_in  in  HEALTH_W  value written by SET, or fill value for INIT.
- rsp_valid  out  1  one-cycle response strobe.
- health  out  HEALTH_W  cell health, held from rsp_valid until the next response. For HIT this is the post-hit value.
- x  out  XY_W  origin of the addressed brick: col*BRICK_W.
- y  out  XY_W  origin of the addressed brick: row*BRICK_H.
- in_grid  out  1  coordinate fell inside the grid.
- hit  out  1  HIT found health > 0.
- destroyed  out  1  HIT took health from 1 to 0.
- bricks_left  out  clog2(COLS*ROWS+1)  count of cells with nonzero health.
- all_clear  out  1  loaded && bricks_left == 0.
- busy  out  1  not in IDLE.

Behaviour:
- **Clock and reset.** One clock. Reset is asynchronous and active-high.
  - On reset, every output goes to 0 except cmd_ready, which goes to 1. Internal loaded = 0; FSM = IDLE.
  - Storage contents are not reset.
  - Reset during INIT aborts the fill; loaded stays 0.
- **Address mapping, computed at accept and registered.**
  - col = x_in / BRICK_W; row = y_in / BRICK_H; addr = row*COLS + col. Integer, truncating.
  - in_grid = (x_in < COLS*BRICK_W) && (y_in < ROWS*BRICK_H).
  - If out of grid: health = 0, hit = 0, destroyed = 0, no write. x and y still report col*BRICK_W and row*BRICK_H, truncated to XY_W.
- **Storage.** COLS*ROWS x HEALTH_W array with synchronous read: data is valid the cycle after the address is presented. One read or one write per cycle.
- **FSM states:** IDLE, RD, RSP, FILL.
  - IDLE: on accept with op LOOKUP, HIT or SET -> RD. On accept with INIT -> FILL.
  - RD: read addr -> RSP.
  - RSP: rsp_valid = 1 and outputs update, then -> IDLE.
    - LOOKUP: health = stored value.
    - HIT: if old > 0, write old-1, set hit = 1, health = old-1, and destroyed = (old == 1). If old == 0: no write, hit = 0.
    - SET: write health_in; health = health_in.
    - The write commits on the RSP edge.
  - FILL: writes health_in to addr 0..COLS*ROWS-1, one per cycle, in ascending order.
    - After the last write: bricks_left = (health_in != 0) ? COLS*ROWS : 0; loaded = 1; rsp_valid pulses; -> IDLE.
    - INIT latency: accept + COLS*ROWS + 1 cycles to rsp_valid.
- **Latency.** Single-cell ops assert rsp_valid exactly 2 cycles after the accept edge. A new command can be accepted on the cycle after rsp_valid, giving a throughput of 1 op per 3 cycles.
- **Counter rules, updated at RSP.**
  - HIT 1 -> 0: decrement.
  - SET old == 0, new != 0: increment.
  - SET old != 0, new == 0: decrement.
  - All other cases: unchanged.
  - The counter never wraps; underflow and overflow are impossible by construction and are assertion-checked.
- **Outputs.** hit and destroyed are cleared at every rsp_valid that is not a HIT. all_clear is combinational from registered state.
- **Handshake.** cmd_valid while busy is ignored; there is no queuing. Inputs are sampled only at accept, so later changes have no effect.

Test Plan:
- **Reset/init, small grid.** Reset, COLS=4, ROWS=2, INIT health_in=3 -> rsp_valid at accept+9, bricks_left=8, all_clear=0, loaded.
- **LOOKUP mapping.** LOOKUP x=45, y=12 (default params) -> x=40, y=10, in_grid=1, health=3, rsp_valid at accept+2.
- **Repeated HIT.** HIT same cell three times -> health 2, 1, 0. destroyed=1 only on the third; bricks_left drops by 1. A fourth HIT gives hit=0, no count change.
- **Out of grid.** HIT x=320, y=5 -> in_grid=0, hit=0, health=0, no change to bricks_left or storage (verify with a following LOOKUP).
- **Clear the field.** SET every cell to 0 after INIT -> bricks_left reaches 0, all_clear=1. Then SET one cell to 2 -> bricks_left=1, all_clear=0.
- **Reset mid-fill.** Assert reset during FILL -> outputs zero immediately, cmd_ready=1, all_clear=0. A cmd_valid pulse while busy is dropped (no extra rsp_valid).
